// File: rtl/game_timer_ctrl_if.sv
// Bundle of the round-timer controls and status outputs; the master drives the
// controls, the slave (the timer) drives the status.
interface game_timer_ctrl_if;
   logic       start;
   logic       pause;
   logic       ko;
   logic [1:0] state;
   logic [6:0] secs_left;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;
   logic       sec_tick;
   logic       time_up;
   logic       warn;

   modport master (
      output start, pause, ko,
      input  state, secs_left, bcd_tens, bcd_ones, sec_tick, time_up, warn
   );

   modport slave (
      input  start, pause, ko,
      output state, secs_left, bcd_tens, bcd_ones, sec_tick, time_up, warn
   );
endinterface

// File: rtl/game_timer_ctrl.sv
// Round countdown timer: a prescaler produces one-second ticks that count a
// round down from ROUND_SECS, with pause, knockout and restart control.
module game_timer_ctrl #(
   parameter int TICK_DIV   = 50000000,
   parameter int ROUND_SECS = 99,
   parameter int WARN_SECS  = 10
) (
   input  logic             clk_in,
   input  logic             rst_n,
   game_timer_ctrl_if.slave bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t        cur_state;
   state_t        next_state;
   logic [PW-1:0] presc;
   logic [6:0]    secs;
   logic          tick_reg;
   logic          time_up_reg;
   logic          tick;
   logic          last_tick;

   // A knockout pre-empts any tick landing on the same edge.
   assign tick      = (cur_state == RUN) && !bus.ko && (presc == PW'(TICK_DIV - 1));
   assign last_tick = tick && (secs == 7'd1);

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= next_state;
      end
   end

   always_comb begin
      next_state = cur_state;
      case (cur_state)
         IDLE: begin
            if (bus.start) next_state = RUN;
         end
         RUN: begin
            if (bus.ko)         next_state = DONE;
            else if (last_tick) next_state = DONE;
            else if (bus.pause) next_state = PAUSE;
         end
         PAUSE: begin
            if (bus.ko)          next_state = DONE;
            else if (!bus.pause) next_state = RUN;
         end
         DONE: begin
            if (bus.start) next_state = RUN;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         presc       <= '0;
         secs        <= 7'(ROUND_SECS);
         tick_reg    <= 1'b0;
         time_up_reg <= 1'b0;
      end else begin
         tick_reg    <= tick;
         time_up_reg <= last_tick;
         case (cur_state)
            IDLE: begin
               presc <= '0;
               secs  <= 7'(ROUND_SECS);
            end
            RUN: begin
               if (tick) begin
                  presc <= '0;
                  secs  <= secs - 7'd1;
               end else if (!bus.ko) begin
                  presc <= presc + PW'(1);
               end
            end
            DONE: begin
               if (bus.start) begin
                  presc <= '0;
                  secs  <= 7'(ROUND_SECS);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Decimal split by comparison chain; secs_left never exceeds 99.
   always_comb begin
      bus.state     = cur_state;
      bus.secs_left = secs;
      bus.sec_tick  = tick_reg;
      bus.time_up   = time_up_reg;
      bus.warn      = ((cur_state == RUN) || (cur_state == PAUSE)) &&
                      (secs <= 7'(WARN_SECS));
      bus.bcd_tens  = 4'd0;
      bus.bcd_ones  = 4'(secs);
      for (int t = 1; t <= 9; t++) begin
         if (secs >= 7'(t * 10)) begin
            bus.bcd_tens = 4'(t);
            bus.bcd_ones = 4'(secs - 7'(t * 10));
         end
      end
   end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, giving the number of clk_in cycles per one-second tick.
REQ-002 The block SHALL have parameter ROUND_SECS, default 99, giving the round length in seconds (legal range 1..99).
REQ-003 The block SHALL have parameter WARN_SECS, default 10, giving the low-time warning threshold in seconds.
REQ-004 clk_in  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  start or restart request, sampled each cycle.
REQ-007 pause  input  1  level; high holds the countdown.
REQ-008 ko  input  1  knockout; ends the round immediately.
REQ-009 state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-010 secs_left  output  7  remaining seconds, binary.
REQ-011 bcd_tens / bcd_ones  output  4 each  BCD digits of secs_left.
REQ-012 sec_tick  output  1  one-cycle pulse per elapsed second.
REQ-013 time_up  output  1  one-cycle pulse when the countdown reaches 0.
REQ-014 warn  output  1  low-time indicator.

Function
REQ-015 The prescaler SHALL be a counter of width ceil(log2(TICK_DIV)) that counts 0..TICK_DIV-1 and advances only in RUN.
REQ-016 In IDLE: secs_left SHALL equal ROUND_SECS and the prescaler SHALL be 0; start=1 SHALL move the block to RUN on the next edge.
REQ-017 In RUN, when the prescaler equals TICK_DIV-1, the block SHALL wrap the prescaler to 0, assert sec_tick for that one cycle, and decrement secs_left by 1, all on the same edge.
REQ-018 A tick that takes secs_left from 1 to 0 SHALL also assert time_up on the same edge and move the block to DONE.
REQ-019 The first tick after start SHALL occur exactly TICK_DIV cycles after the edge on which start was sampled.
REQ-020 pause=1 in RUN SHALL move the block to PAUSE on the next edge; the prescaler and secs_left SHALL hold in PAUSE.
REQ-021 pause=0 in PAUSE SHALL return the block to RUN, and the prescaler SHALL resume from its held value.
REQ-022 If pause and a tick coincide in RUN, the tick SHALL complete (decrement, sec_tick, and time_up if applicable) and the next state SHALL be PAUSE, or DONE if secs_left reached 0.
REQ-023 ko=1 in RUN or PAUSE SHALL move the block to DONE on the next edge with secs_left frozen, no decrement, and no time_up.
REQ-024 ko SHALL take priority over a coincident tick.
REQ-025 ko SHALL be ignored in IDLE and DONE.
REQ-026 In DONE, start=1 SHALL reload secs_left to ROUND_SECS, clear the prescaler, and enter RUN.
REQ-027 start SHALL be ignored in RUN and PAUSE.
REQ-028 bcd_tens and bcd_ones SHALL be the combinational decimal split of secs_left (for example 37 -> 3,7).
REQ-029 warn SHALL be 1 iff state is RUN or PAUSE and secs_left <= WARN_SECS.
REQ-030 sec_tick and time_up SHALL never be high for more than one consecutive cycle.

Reset
REQ-031 When rst_n=0 at an edge, the block SHALL set state=IDLE, prescaler=0, secs_left=ROUND_SECS, sec_tick=0, time_up=0, and warn=0, overriding all other inputs.
REQ-032 Reset asserted mid-round (RUN, PAUSE or DONE) SHALL abort the round with no time_up pulse.
REQ-033 Outputs SHALL be undefined only before the first reset edge.

Verification (TICK_DIV=4, ROUND_SECS=3, WARN_SECS=2)
REQ-034 Reset test: hold rst_n=0 for 2 cycles -> state=00, secs_left=3, bcd=0/3, all pulses and warn 0.
REQ-035 Full countdown: start pulse at cycle 0 -> sec_tick at cycles 4, 8 and 12; secs_left goes 2, 1, 0; time_up at cycle 12 only; state=11 from cycle 12; warn=1 from cycle 4 until DONE.
REQ-036 Pause: hold pause high for 10 cycles starting at cycle 2 after start -> first sec_tick delayed to cycle 14 (±1 for pause entry/exit edges, checked exactly against REQ-020/021); secs_left unchanged while paused.
REQ-037 KO: ko at cycle 6 after start -> state=11, secs_left=2 held; no further sec_tick; time_up never asserted.
REQ-038 Coincidence: ko on the tick cycle -> no decrement; pause on the tick cycle -> decrement, then PAUSE.
REQ-039 Reset and restart: rst_n=0 during RUN -> IDLE with secs_left=3; a start in DONE -> secs_left=3 and RUN, with the next tick 4 cycles later.
